fft_butterfly_pipe: RTL and testbench

FFT_BUTTERFLY_PIPE -- requirements
Module: fft_butterfly_pipe

---
 rtl/fft_butterfly_pipe.sv | 188 ++++++++++++++++++
 tb/tb_fft_butterfly_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly_pipe.sv
// Radix-2 DIT butterfly, 3-stage pipeline: Y = A + W*B, Z = A - W*B with a twiddle ROM built at elaboration.
// Define BUTTERFLY_SATURATE_EN to clamp out-of-range results; otherwise results wrap to DATA_W bits.
module fft_butterfly_pipe #(
   parameter int DATA_W    = 8,
   parameter int TW_ADDR_W = 3
) (
   input  logic                        Clock,
   input  logic                        nReset,
   input  logic                        clear,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [DATA_W-1:0]    a_re,
   input  logic signed [DATA_W-1:0]    a_im,
   input  logic signed [DATA_W-1:0]    b_re,
   input  logic signed [DATA_W-1:0]    b_im,
   input  logic [TW_ADDR_W-1:0]        tw_idx,
   input  logic                        scale,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [DATA_W-1:0]    y_re,
   output logic signed [DATA_W-1:0]    y_im,
   output logic signed [DATA_W-1:0]    z_re,
   output logic signed [DATA_W-1:0]    z_im,
   output logic                        ovf
);

   localparam int  NPT = 2 ** (TW_ADDR_W + 1);
   localparam int  NTW = 2 ** TW_ADDR_W;
   localparam int  PW  = 2 * DATA_W;
   localparam int  WBW = 2 * DATA_W + 1;
   localparam int  SW  = DATA_W + 2;
   localparam real PI  = 3.14159265358979323846;

   localparam logic signed [WBW-1:0] RND   = WBW'(2 ** (DATA_W - 2));
   localparam logic signed [SW-1:0]  MAX_V = SW'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [SW-1:0]  MIN_V = SW'(-(2 ** (DATA_W - 1)));

   // Round-half-away-from-zero of cos/sin scaled to full Q1 range.
   function automatic logic signed [DATA_W-1:0] tw_val(input int k, input logic imag);
      real ang;
      real mag;
      real r;
      int  q;
      ang = 2.0 * PI * real'(k) / real'(NPT);
      mag = real'(2 ** (DATA_W - 1) - 1);
      r   = imag ? -($sin(ang) * mag) : ($cos(ang) * mag);
      q   = (r >= 0.0) ? int'($floor(r + 0.5)) : -int'($floor(-r + 0.5));
      return DATA_W'(q);
   endfunction

   function automatic logic signed [SW-1:0] round_wb(input logic signed [WBW-1:0] x);
      logic signed [WBW-1:0] t;
      t = (x + RND) >>> (DATA_W - 1);
      return SW'(t);
   endfunction

   function automatic logic signed [SW-1:0] post_scale(input logic signed [SW-1:0] s, input logic sc);
      logic signed [SW-1:0] t;
      t = (s + SW'(1)) >>> 1;
      return sc ? t : s;
   endfunction

   function automatic logic out_of_range(input logic signed [SW-1:0] v);
      return (v > MAX_V) || (v < MIN_V);
   endfunction

   function automatic logic signed [DATA_W-1:0] reduce(input logic signed [SW-1:0] v);
      logic signed [DATA_W-1:0] r;
`ifdef BUTTERFLY_SATURATE_EN
      if (v > MAX_V)      r = DATA_W'(MAX_V);
      else if (v < MIN_V) r = DATA_W'(MIN_V);
      else                r = DATA_W'(v);
`else
      r = DATA_W'(v);
`endif
      return r;
   endfunction

   logic signed [DATA_W-1:0] rom_re [NTW];
   logic signed [DATA_W-1:0] rom_im [NTW];

   for (genvar g = 0; g < NTW; g++) begin : g_rom
      assign rom_re[g] = tw_val(g, 1'b0);
      assign rom_im[g] = tw_val(g, 1'b1);
   end

   // Stage 1: operands, twiddle, scale
   logic                     v1_q, v1_d, sc1_q, sc1_d;
   logic signed [DATA_W-1:0] a_re1_q, a_re1_d, a_im1_q, a_im1_d;
   logic signed [DATA_W-1:0] b_re1_q, b_re1_d, b_im1_q, b_im1_d;
   logic signed [DATA_W-1:0] wr1_q, wr1_d, wi1_q, wi1_d;
   // Stage 2: products
   logic                     v2_q, v2_d, sc2_q, sc2_d;
   logic signed [DATA_W-1:0] a_re2_q, a_re2_d, a_im2_q, a_im2_d;
   logic signed [PW-1:0]     p_rr_q, p_rr_d, p_ii_q, p_ii_d, p_ri_q, p_ri_d, p_ir_q, p_ir_d;
   // Stage 3: results
   logic                     v3_q, v3_d, ovf_q, ovf_d;
   logic signed [DATA_W-1:0] y_re_q, y_re_d, y_im_q, y_im_d, z_re_q, z_re_d, z_im_q, z_im_d;

   logic                     adv;
   logic signed [SW-1:0]     wb_re_s, wb_im_s, y_re_s, y_im_s, z_re_s, z_im_s;

   // The whole pipe freezes only when a result is waiting and the sink refuses it.
   assign adv       = !(v3_q && !out_ready);
   assign in_ready  = adv;
   assign out_valid = v3_q;
   assign ovf       = ovf_q;
   assign y_re      = y_re_q;
   assign y_im      = y_im_q;
   assign z_re      = z_re_q;
   assign z_im      = z_im_q;

   always_comb begin
      wb_re_s = round_wb(WBW'(p_rr_q) - WBW'(p_ii_q));
      wb_im_s = round_wb(WBW'(p_ri_q) + WBW'(p_ir_q));
      y_re_s  = post_scale(SW'(a_re2_q) + wb_re_s, sc2_q);
      y_im_s  = post_scale(SW'(a_im2_q) + wb_im_s, sc2_q);
      z_re_s  = post_scale(SW'(a_re2_q) - wb_re_s, sc2_q);
      z_im_s  = post_scale(SW'(a_im2_q) - wb_im_s, sc2_q);
   end

   always_comb begin
      v1_d = v1_q;  sc1_d = sc1_q;
      a_re1_d = a_re1_q;  a_im1_d = a_im1_q;  b_re1_d = b_re1_q;  b_im1_d = b_im1_q;
      wr1_d = wr1_q;  wi1_d = wi1_q;
      v2_d = v2_q;  sc2_d = sc2_q;  a_re2_d = a_re2_q;  a_im2_d = a_im2_q;
      p_rr_d = p_rr_q;  p_ii_d = p_ii_q;  p_ri_d = p_ri_q;  p_ir_d = p_ir_q;
      v3_d = v3_q;  ovf_d = ovf_q;
      y_re_d = y_re_q;  y_im_d = y_im_q;  z_re_d = z_re_q;  z_im_d = z_im_q;

      if (adv) begin
         v1_d = in_valid;
         if (in_valid) begin
            a_re1_d = a_re;  a_im1_d = a_im;  b_re1_d = b_re;  b_im1_d = b_im;
            wr1_d   = rom_re[tw_idx];
            wi1_d   = rom_im[tw_idx];
            sc1_d   = scale;
         end
         v2_d = v1_q;
         if (v1_q) begin
            p_rr_d  = PW'(wr1_q) * PW'(b_re1_q);
            p_ii_d  = PW'(wi1_q) * PW'(b_im1_q);
            p_ri_d  = PW'(wr1_q) * PW'(b_im1_q);
            p_ir_d  = PW'(wi1_q) * PW'(b_re1_q);
            a_re2_d = a_re1_q;
            a_im2_d = a_im1_q;
            sc2_d   = sc1_q;
         end
         v3_d = v2_q;
         if (v2_q) begin
            y_re_d = reduce(y_re_s);
            y_im_d = reduce(y_im_s);
            z_re_d = reduce(z_re_s);
            z_im_d = reduce(z_im_s);
            ovf_d  = ovf_q | out_of_range(y_re_s) | out_of_range(y_im_s)
                           | out_of_range(z_re_s) | out_of_range(z_im_s);
         end
      end

      if (clear) begin
         v1_d  = 1'b0;
         v2_d  = 1'b0;
         v3_d  = 1'b0;
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         v1_q <= 1'b0;  sc1_q <= 1'b0;
         a_re1_q <= '0;  a_im1_q <= '0;  b_re1_q <= '0;  b_im1_q <= '0;
         wr1_q <= '0;  wi1_q <= '0;
         v2_q <= 1'b0;  sc2_q <= 1'b0;  a_re2_q <= '0;  a_im2_q <= '0;
         p_rr_q <= '0;  p_ii_q <= '0;  p_ri_q <= '0;  p_ir_q <= '0;
         v3_q <= 1'b0;  ovf_q <= 1'b0;
         y_re_q <= '0;  y_im_q <= '0;  z_re_q <= '0;  z_im_q <= '0;
      end else begin
         v1_q <= v1_d;  sc1_q <= sc1_d;
         a_re1_q <= a_re1_d;  a_im1_q <= a_im1_d;  b_re1_q <= b_re1_d;  b_im1_q <= b_im1_d;
         wr1_q <= wr1_d;  wi1_q <= wi1_d;
         v2_q <= v2_d;  sc2_q <= sc2_d;  a_re2_q <= a_re2_d;  a_im2_q <= a_im2_d;
         p_rr_q <= p_rr_d;  p_ii_q <= p_ii_d;  p_ri_q <= p_ri_d;  p_ir_q <= p_ir_d;
         v3_q <= v3_d;  ovf_q <= ovf_d;
         y_re_q <= y_re_d;  y_im_q <= y_im_d;  z_re_q <= z_re_d;  z_im_q <= z_im_d;
      end
   end

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Bench for fft_butterfly_pipe (DATA_W=8, TW_ADDR_W=3): directed cases plus random traffic,
// scored by a monitor against an integer reference model of the butterfly.
module tb_fft_butterfly_pipe;

   localparam real PI = 3.14159265358979323846;

   logic              Clock = 1'b0;
   logic              nReset = 1'b0;
   logic              clear = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic signed [7:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
   logic [2:0]        tw_idx = '0;
   logic              scale = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic signed [7:0] y_re, y_im, z_re, z_im;
   logic              ovf;

   fft_butterfly_pipe #(.DATA_W(8), .TW_ADDR_W(3)) dut (
      .Clock(Clock), .nReset(nReset), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .tw_idx(tw_idx), .scale(scale),
      .out_valid(out_valid), .out_ready(out_ready),
      .y_re(y_re), .y_im(y_im), .z_re(z_re), .z_im(z_im),
      .ovf(ovf)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 Clock = ~Clock;

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [32:0] exp_q[$];       // {sample_ovf, y_re, y_im, z_re, z_im}
   int          due_q[$];       // expected first-visible cycle, -1 when not timed
   logic        ovf_sticky = 1'b0;
   int          n_checks = 0;
   int          n_pass = 0;
   logic        rand_ready = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   function automatic int rnd(input real r);
      return (r >= 0.0) ? int'($floor(r + 0.5)) : -int'($floor(-r + 0.5));
   endfunction

   function automatic int wrap_or_sat(input int v);
      int w;
`ifdef BUTTERFLY_SATURATE_EN
      w = (v > 127) ? 127 : ((v < -128) ? -128 : v);
`else
      w = v & 255;
      if (w > 127) w -= 256;
`endif
      return w;
   endfunction

   function automatic logic [32:0] pk(input bit o, input int yr, input int yi, input int zr, input int zi);
      logic [7:0] p0, p1, p2, p3;
      p0 = yr[7:0];  p1 = yi[7:0];  p2 = zr[7:0];  p3 = zi[7:0];
      return {o, p0, p1, p2, p3};
   endfunction

   function automatic logic [32:0] model(input int ar, input int ai, input int br, input int bi,
                                         input int k, input bit sc);
      int  wr, wi, wbr, wbi, yr, yi, zr, zi;
      bit  o;
      wr  = rnd($cos(2.0 * PI * k / 16.0) * 127.0);
      wi  = -rnd($sin(2.0 * PI * k / 16.0) * 127.0);
      wbr = (wr * br - wi * bi + 64) >>> 7;
      wbi = (wr * bi + wi * br + 64) >>> 7;
      yr = ar + wbr;  yi = ai + wbi;  zr = ar - wbr;  zi = ai - wbi;
      if (sc) begin
         yr = (yr + 1) >>> 1;  yi = (yi + 1) >>> 1;
         zr = (zr + 1) >>> 1;  zi = (zi + 1) >>> 1;
      end
      o = (yr > 127) || (yr < -128) || (yi > 127) || (yi < -128) ||
          (zr > 127) || (zr < -128) || (zi > 127) || (zi < -128);
      return pk(o, wrap_or_sat(yr), wrap_or_sat(yi), wrap_or_sat(zr), wrap_or_sat(zi));
   endfunction

   // ---------------- driver tasks (start and end on a falling edge) ----------------
   task automatic send(input int ar, input int ai, input int br, input int bi, input int k,
                       input bit sc, input bit timed, input logic [32:0] exp);
      int waited = 0;
      in_valid = 1'b1;
      a_re = ar[7:0];  a_im = ai[7:0];  b_re = br[7:0];  b_im = bi[7:0];
      tw_idx = k[2:0];  scale = sc;
      #1;
      while (!in_ready && waited < 50) begin
         @(negedge Clock);
         #1;
         waited++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 32'(in_ready), 32'd1);
      end else begin
         exp_q.push_back(exp);
         due_q.push_back(timed ? cyc + 3 : -1);
      end
      @(negedge Clock);
      in_valid = 1'b0;
   endtask

   task automatic send_rand(input bit timed);
      int ar, ai, br, bi, k;
      bit sc;
      ar = int'($urandom_range(0, 255)) - 128;
      ai = int'($urandom_range(0, 255)) - 128;
      br = int'($urandom_range(0, 255)) - 128;
      bi = int'($urandom_range(0, 255)) - 128;
      k  = int'($urandom_range(0, 7));
      sc = 1'($urandom_range(0, 1));
      send(ar, ai, br, bi, k, sc, timed, model(ar, ai, br, bi, k, sc));
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge Clock);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic flush_model();
      exp_q.delete();
      due_q.delete();
      ovf_sticky = 1'b0;
   endtask

   // ---------------- random sink backpressure ----------------
   initial forever begin
      @(negedge Clock);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   end

   // ---------------- monitor ----------------
   initial forever begin
      logic [32:0] e;
      int          d;
      @(negedge Clock);
      #1;
      if (nReset && out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
         end else begin
            e = exp_q[0];
            check("y_z", {y_re, y_im, z_re, z_im}, e[31:0]);
            if (out_ready) begin
               void'(exp_q.pop_front());
               d = due_q.pop_front();
               ovf_sticky = ovf_sticky | e[32];
               check("ovf", 32'(ovf), 32'(ovf_sticky));
               if (d >= 0) check("latency", 32'(cyc), 32'(d));
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   logic [7:0] yre_ovf;

   initial begin
`ifdef BUTTERFLY_SATURATE_EN
      yre_ovf = 8'd127;
`else
      yre_ovf = 8'hC7;   // -57
`endif
      // reset state
      repeat (2) @(negedge Clock);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_data", {y_re, y_im, z_re, z_im}, 32'd0);
      @(negedge Clock);
      nReset = 1'b1;
      @(negedge Clock);

      // k=0, simple add/sub; k=4, rotation by -j
      send(10, 0, 64, 0, 0, 1'b0, 1'b1, pk(1'b0, 74, 0, -54, 0));
      drain();
      send(0, 0, 64, 0, 4, 1'b0, 1'b1, pk(1'b0, 0, -63, 0, 63));
      drain();

      // overflow is sticky across a clean sample, cleared only by clear
      send(100, 0, 100, 0, 0, 1'b0, 1'b1, pk(1'b1, int'($signed(yre_ovf)), 0, 1, 0));
      send(10, 0, 64, 0, 0, 1'b0, 1'b1, pk(1'b0, 74, 0, -54, 0));
      drain();
      #1;
      check("ovf_held", 32'(ovf), 32'd1);
      @(negedge Clock);
      clear = 1'b1;
      @(negedge Clock);
      clear = 1'b0;
      ovf_sticky = 1'b0;
      #1;
      check("ovf_cleared", 32'(ovf), 32'd0);
      check("clear_out_valid", 32'(out_valid), 32'd0);
      @(negedge Clock);

      // same operands halved: no overflow
      send(100, 0, 100, 0, 0, 1'b1, 1'b1, pk(1'b0, 100, 0, 1, 0));
      drain();

      // clear mid-flight discards samples and ignores a simultaneous in_valid
      send_rand(1'b0);
      send_rand(1'b0);
      clear = 1'b1;
      in_valid = 1'b1;
      a_re = 8'sd5;
      @(negedge Clock);
      clear = 1'b0;
      in_valid = 1'b0;
      flush_model();
      for (int i = 0; i < 5; i++) begin
         #1;
         check("clear_flush", 32'(out_valid), 32'd0);
         @(negedge Clock);
      end

      // back-to-back with a blocked sink: in_ready drops once three are held
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_rand(1'b0);
      fork
         begin
            repeat (5) @(negedge Clock);
            out_ready = 1'b1;
         end
      join_none
      #1;
      check("in_ready_full", 32'(in_ready), 32'd0);
      check("held_out_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 3; i++) send_rand(1'b0);
      drain();

      // random traffic with random backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 80; i++) begin
         send_rand(1'b0);
         repeat ($urandom_range(0, 2)) @(negedge Clock);
      end
      rand_ready = 1'b0;
      out_ready = 1'b1;
      drain();

      // back-to-back under a free-flowing sink keeps 1 sample/cycle
      for (int i = 0; i < 6; i++) send_rand(1'b1);
      drain();

      // reset with two samples in flight
      @(negedge Clock);
      clear = 1'b1;
      @(negedge Clock);
      clear = 1'b0;
      ovf_sticky = 1'b0;
      send(100, 0, 100, 0, 0, 1'b0, 1'b1, pk(1'b1, int'($signed(yre_ovf)), 0, 1, 0));
      drain();
      send_rand(1'b0);
      send_rand(1'b0);
      nReset = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ovf", 32'(ovf), 32'd0);
      check("mid_rst_data", {y_re, y_im, z_re, z_im}, 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      flush_model();
      @(negedge Clock);
      nReset = 1'b1;
      @(negedge Clock);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("post_rst_idle", 32'(out_valid), 32'd0);
         @(negedge Clock);
      end
      send(10, 0, 64, 0, 0, 1'b0, 1'b1, pk(1'b0, 74, 0, -54, 0));
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
